// File: rtl/vedic_pkg.sv
// Shared widths and types for the Vedic multiplier cells.
package vedic_pkg;

    localparam int unsigned VEDIC_OP_W   = 2;
    localparam int unsigned VEDIC_PROD_W = 4;

    typedef logic [VEDIC_OP_W-1:0]   vedic_op_t;
    typedef logic [VEDIC_PROD_W-1:0] vedic_prod_t;

endpackage : vedic_pkg

// File: rtl/vedic_ha.sv
// Half adder used for the crosswise and carry columns of the 2x2 Vedic cell.
module vedic_ha (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    // Sum and carry of two single-bit addends.
    assign s = x ^ y;
    assign c = x & y;

endmodule : vedic_ha

// File: rtl/vedic_2b_mul.sv
// Two-bit unsigned Urdhva-Tiryagbhyam multiplier with a combinational product
// and a one-cycle registered copy qualified by out_valid.
// Optional: define VEDIC2B_SELFCHECK_EN to add a behavioural reference
// comparator and the sticky chk_err output.
module vedic_2b_mul
    import vedic_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [VEDIC_OP_W-1:0]   a,
    input  logic [VEDIC_OP_W-1:0]   b,
    input  logic                    in_valid,
    output logic [VEDIC_PROD_W-1:0] o,
    output logic [VEDIC_PROD_W-1:0] o_q,
`ifdef VEDIC2B_SELFCHECK_EN
    output logic                    out_valid,
    output logic                    chk_err
`else
    output logic                    out_valid
`endif
);

    logic p00;
    logic p10;
    logic p01;
    logic p11;
    logic s1;
    logic c1;
    logic s2;
    logic c2;

    // Vertical and crosswise partial products.
    assign p00 = a[0] & b[0];
    assign p10 = a[1] & b[0];
    assign p01 = a[0] & b[1];
    assign p11 = a[1] & b[1];

    // Crosswise column: adds the two middle partial products.
    vedic_ha u_ha1 (
        .x (p10),
        .y (p01),
        .s (s1),
        .c (c1)
    );

    // Left vertical column: absorbs the crosswise carry into p11.
    vedic_ha u_ha2 (
        .x (p11),
        .y (c1),
        .s (s2),
        .c (c2)
    );

    // Assemble the product; o[3] only rises for 3*3.
    assign o = {c2, s2, s1, p00};

    // Capture the product on each valid input; o_q holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                o_q <= o;
            end
        end
    end

`ifdef VEDIC2B_SELFCHECK_EN
    logic [VEDIC_PROD_W-1:0] ref_prod;

    // Behavioural reference product for cross-checking the structural datapath.
    assign ref_prod = VEDIC_PROD_W'(a) * VEDIC_PROD_W'(b);

    // Sticky mismatch flag, sampled only on valid inputs and cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err <= 1'b0;
        end else if (in_valid && (o != ref_prod)) begin
            chk_err <= 1'b1;
`ifndef SYNTHESIS
            $error("vedic_2b_mul: structural product %0d differs from reference %0d for a=%0d b=%0d",
                   o, ref_prod, a, b);
`endif
        end
    end
`endif

endmodule : vedic_2b_mul

// File: tb/tb_vedic_2b_mul.sv
// Directed self-checking bench for vedic_2b_mul.
module tb_vedic_2b_mul;

    logic       clk;
    logic       rst_n;
    logic [1:0] a;
    logic [1:0] b;
    logic       in_valid;
    logic [3:0] o;
    logic [3:0] o_q;
    logic       out_valid;
`ifdef VEDIC2B_SELFCHECK_EN
    logic       chk_err;
`endif

    int errors = 0;
    int checks = 0;

    vedic_2b_mul dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .o         (o),
        .o_q       (o_q),
`ifdef VEDIC2B_SELFCHECK_EN
        .out_valid (out_valid),
        .chk_err   (chk_err)
`else
        .out_valid (out_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        logic [3:0] exp_o;

        // Reset state
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 2'd0;
        b        = 2'd0;
        #1;
        check("reset_o_q", int'(o_q), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_o", int'(o), 0);
`ifdef VEDIC2B_SELFCHECK_EN
        check("reset_chk_err", int'(chk_err), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive combinational sweep
        for (int ai = 0; ai < 4; ai++) begin
            for (int bi = 0; bi < 4; bi++) begin
                a = 2'(ai);
                b = 2'(bi);
                #1;
                exp_o = 4'(ai * bi);
                check($sformatf("exh_%0dx%0d", ai, bi), int'(o), int'(exp_o));
            end
        end

        // Hand-computed directed vectors
        a = 2'd2; b = 2'd3; #1; check("dir_2x3", int'(o), 6);
        a = 2'd3; b = 2'd3; #1; check("dir_3x3", int'(o), 9);
        a = 2'd1; b = 2'd2; #1; check("dir_1x2", int'(o), 2);
        a = 2'd1; b = 2'd3; #1; check("dir_1x3", int'(o), 3);
        a = 2'd0; b = 2'd3; #1; check("dir_0x3", int'(o), 0);
        a = 2'd3; b = 2'd2; #1; check("dir_3x2", int'(o), 6);
        check("idle_o_q_hold", int'(o_q), 0);
        check("idle_out_valid", int'(out_valid), 0);

        // Registered path: one valid sample then idle
        @(negedge clk);
        a = 2'd2; b = 2'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        check("reg_o_q", int'(o_q), 6);
        check("reg_out_valid", int'(out_valid), 1);
        in_valid = 1'b0; a = 2'd1; b = 2'd1;
        @(posedge clk); #1;
        check("hold_out_valid", int'(out_valid), 0);
        check("hold_o_q", int'(o_q), 6);

        // Back-to-back valid inputs
        @(negedge clk);
        a = 2'd3; b = 2'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        check("b2b_first_o_q", int'(o_q), 9);
        check("b2b_first_valid", int'(out_valid), 1);
        a = 2'd1; b = 2'd1;
        @(posedge clk); #1;
        check("b2b_second_o_q", int'(o_q), 1);
        check("b2b_second_valid", int'(out_valid), 1);

        // Reset asserted between edges while a result is held
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_o_q", int'(o_q), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_o", int'(o), 1);
        a = 2'd2; b = 2'd2;
        #1;
        check("midrst_o_track", int'(o), 4);
`ifdef VEDIC2B_SELFCHECK_EN
        check("midrst_chk_err", int'(chk_err), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        a = 2'd3; b = 2'd2; in_valid = 1'b1;

        // First edge after reset release is sampled normally
        @(posedge clk); #1;
        check("post_rst_o_q", int'(o_q), 6);
        check("post_rst_valid", int'(out_valid), 1);

        // Random vectors with in_valid held high
        for (int i = 0; i < 100; i++) begin
            a = 2'($urandom_range(0, 3));
            b = 2'($urandom_range(0, 3));
            #1;
            exp_o = 4'(int'(a) * int'(b));
            check($sformatf("rand_%0d", i), int'(o), int'(exp_o));
            #4;
        end
`ifdef VEDIC2B_SELFCHECK_EN
        check("rand_chk_err", int'(chk_err), 0);
`endif
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("final_out_valid", int'(out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_vedic_2b_mul
